ip_param_sched: RTL and testbench

- Sequences the fully-connected (inner-product) layer parameter path.
- Per output neuron, fetches bias plus weights from DDR into the ping-pong param buffer. Then releases the neuron to the datapath by pulsing neuron-start and streaming the buffer read enable.
- Sits between the DDR read port, the param buffer controller (full/busy/sel status) and the IP MAC datapath.

---
 rtl/ip_param_sched.sv | 164 ++++++++++++++++
 tb/tb_ip_param_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_param_sched.sv
// rtl/ip_param_sched.sv - FC-layer parameter fetch/release scheduler; optional macro IP_SCHED_PREFETCH_EN
module ip_param_sched #(
  parameter logic [8:0] WL = 9'd288,
  parameter int         AW = 30,
  parameter int         NW = 12
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ip_start_i,
  input  logic [NW-1:0] ip_neuron_num_i,
  input  logic [AW-1:0] ip_param_base_i,
  output logic          ddr_rd_req_o,
  output logic [AW-1:0] ddr_rd_addr_o,
  output logic [8:0]    ddr_rd_len_o,
  input  logic          ddr_rd_ack_i,
  input  logic          ddr_data_valid_i,
  output logic          wr_buf_en_o,
  output logic [8:0]    wr_buf_addr_o,
  output logic          wr_buf_done_o,
  input  logic          wr_buf_sel_i,
  input  logic [1:0]    param_buf_full_i,
  input  logic          dp_ready_i,
  output logic          rd_buf_en_o,
  input  logic          rd_buf_done_i,
  output logic          ip_oneuron_start_o,
  output logic          ip_oneuron_done_o,
  output logic          ip_done_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {W_IDLE, W_WAIT, W_REQ, W_DATA, W_DONE} w_state_e;
  typedef enum logic [2:0] {R_IDLE, R_WAIT, R_START, R_READ, R_DONE} r_state_e;

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic          busy_q, busy_d;
  logic [NW-1:0] num_q, num_d;
  logic [NW-1:0] fetch_idx_q, fetch_idx_d;
  logic [NW-1:0] done_idx_q, done_idx_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic [8:0]    waddr_q, waddr_d;
  logic          rd_sel_q, rd_sel_d;

  logic          start_acc;
  logic          layer_done;
  logic          fetch_ok;
  logic [NW-1:0] done_idx_inc;

  assign start_acc    = ip_start_i & ~busy_q;
  assign done_idx_inc = done_idx_q + NW'(1);
  assign layer_done   = (r_state_q == R_DONE) && (done_idx_inc == num_q);

`ifdef IP_SCHED_PREFETCH_EN
  // Fetch whenever the targeted buffer is free: up to two neurons in flight.
  assign fetch_ok = ~param_buf_full_i[wr_buf_sel_i] && (fetch_idx_q < num_q);
`else
  // Fetch only once every fetched neuron has been consumed: one neuron in flight.
  assign fetch_ok = ~param_buf_full_i[wr_buf_sel_i] && (fetch_idx_q < num_q)
                    && (fetch_idx_q == done_idx_q);
`endif

  // Write side: request a burst per neuron and fill the buffer top-down (bias lands at WL).
  always_comb begin
    w_state_d   = w_state_q;
    fetch_idx_d = fetch_idx_q;
    next_addr_d = next_addr_q;
    waddr_d     = waddr_q;
    case (w_state_q)
      W_IDLE: begin
        if (start_acc) begin
          w_state_d   = W_WAIT;
          fetch_idx_d = '0;
          next_addr_d = ip_param_base_i;
        end
      end
      W_WAIT: if (fetch_ok) w_state_d = W_REQ;
      W_REQ:  if (ddr_rd_ack_i) w_state_d = W_DATA;
      W_DATA: begin
        if (ddr_data_valid_i) begin
          if (waddr_q == 9'd0) w_state_d = W_DONE;
          else                 waddr_d   = waddr_q - 9'd1;
        end
      end
      W_DONE: begin
        waddr_d     = WL;
        fetch_idx_d = fetch_idx_q + NW'(1);
        next_addr_d = next_addr_q + AW'(WL) + AW'(1);
        w_state_d   = (fetch_idx_d == num_q) ? W_IDLE : W_WAIT;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (layer_done) w_state_d = W_IDLE;
  end

  // Read side: release each filled buffer to the datapath and track layer completion.
  always_comb begin
    r_state_d  = r_state_q;
    busy_d     = busy_q;
    num_d      = num_q;
    done_idx_d = done_idx_q;
    rd_sel_d   = rd_sel_q;
    if (start_acc) begin
      busy_d     = 1'b1;
      num_d      = ip_neuron_num_i;
      done_idx_d = '0;
      rd_sel_d   = 1'b0;
    end
    case (r_state_q)
      R_IDLE:  if (start_acc) r_state_d = R_WAIT;
      R_WAIT:  if (param_buf_full_i[rd_sel_q] && dp_ready_i) r_state_d = R_START;
      R_START: r_state_d = R_READ;
      R_READ:  if (rd_buf_done_i) r_state_d = R_DONE;
      R_DONE: begin
        rd_sel_d   = ~rd_sel_q;
        done_idx_d = done_idx_inc;
        if (layer_done) begin
          r_state_d = R_IDLE;
          busy_d    = 1'b0;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      busy_q      <= 1'b0;
      num_q       <= '0;
      fetch_idx_q <= '0;
      done_idx_q  <= '0;
      next_addr_q <= '0;
      waddr_q     <= WL;
      rd_sel_q    <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      busy_q      <= busy_d;
      num_q       <= num_d;
      fetch_idx_q <= fetch_idx_d;
      done_idx_q  <= done_idx_d;
      next_addr_q <= next_addr_d;
      waddr_q     <= waddr_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  assign ddr_rd_req_o       = (w_state_q == W_REQ);
  assign ddr_rd_addr_o      = ddr_rd_req_o ? next_addr_q : '0;
  assign ddr_rd_len_o       = ddr_rd_req_o ? (WL + 9'd1) : 9'd0;
  assign wr_buf_en_o        = (w_state_q == W_DATA) & ddr_data_valid_i;
  assign wr_buf_addr_o      = waddr_q;
  assign wr_buf_done_o      = (w_state_q == W_DONE);
  assign rd_buf_en_o        = (r_state_q == R_READ);
  assign ip_oneuron_start_o = (r_state_q == R_START);
  assign ip_oneuron_done_o  = (r_state_q == R_DONE);
  assign ip_done_o          = layer_done;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_ip_param_sched.sv
// tb/tb_ip_param_sched.sv - randomized self-checking bench for ip_param_sched
`timescale 1ns/1ps
module tb_ip_param_sched;
  localparam int WL  = 288;
  localparam int AW  = 30;
  localparam int NW  = 12;
  localparam int LIM = 20000;

  logic          clk_i = 1'b0;
  logic          rstn_i, ip_start_i;
  logic [NW-1:0] ip_neuron_num_i;
  logic [AW-1:0] ip_param_base_i;
  logic          ddr_rd_req_o;
  logic [AW-1:0] ddr_rd_addr_o;
  logic [8:0]    ddr_rd_len_o;
  logic          ddr_rd_ack_i, ddr_data_valid_i;
  logic          wr_buf_en_o;
  logic [8:0]    wr_buf_addr_o;
  logic          wr_buf_done_o, wr_buf_sel_i;
  logic [1:0]    param_buf_full_i;
  logic          dp_ready_i, rd_buf_en_o, rd_buf_done_i;
  logic          ip_oneuron_start_o, ip_oneuron_done_o, ip_done_o, busy_o;

  always #5 clk_i = ~clk_i;

  ip_param_sched dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ip_start_i(ip_start_i),
    .ip_neuron_num_i(ip_neuron_num_i), .ip_param_base_i(ip_param_base_i),
    .ddr_rd_req_o(ddr_rd_req_o), .ddr_rd_addr_o(ddr_rd_addr_o), .ddr_rd_len_o(ddr_rd_len_o),
    .ddr_rd_ack_i(ddr_rd_ack_i), .ddr_data_valid_i(ddr_data_valid_i),
    .wr_buf_en_o(wr_buf_en_o), .wr_buf_addr_o(wr_buf_addr_o), .wr_buf_done_o(wr_buf_done_o),
    .wr_buf_sel_i(wr_buf_sel_i), .param_buf_full_i(param_buf_full_i), .dp_ready_i(dp_ready_i),
    .rd_buf_en_o(rd_buf_en_o), .rd_buf_done_i(rd_buf_done_i),
    .ip_oneuron_start_o(ip_oneuron_start_o), .ip_oneuron_done_o(ip_oneuron_done_o),
    .ip_done_o(ip_done_o), .busy_o(busy_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus knobs
  int ack_delay_cfg = -1;
  bit gap_en = 1'b0;
  bit stray_en = 1'b0;

  // Buffer controller model
  logic [1:0] full;
  bit         wsel, rsel;
  int         rd_cnt;
  assign param_buf_full_i = full;
  assign wr_buf_sel_i     = wsel;
  assign rd_buf_done_i    = rd_buf_en_o && (rd_cnt == WL);

  // Values seen just before each rising edge
  bit s_wr_done, s_rd_en, s_rd_done, s_ip_done;

  // Reference model of one layer
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] req_addr_lat;
  int  exp_waddr, wr_in_burst, en_cnt, start_cnt, od_cnt, req_cnt, ipdone_cnt, layer_n;
  longint cyc = 0, req2_cyc, od1_cyc;
  bit  prev_req;

  task automatic init_model(input int n, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i * (WL + 1));
      exp_addr_q.push_back(a);
    end
    exp_waddr = WL; wr_in_burst = 0; en_cnt = 0; start_cnt = 0; od_cnt = 0;
    req_cnt = 0; ipdone_cnt = 0; layer_n = n; req2_cyc = -1; od1_cyc = -1; prev_req = 1'b0;
  endtask

  // DDR responder plus buffer full/sel bookkeeping
  initial begin : drv
    int phase, dly, beats;
    phase = 0; dly = 0; beats = 0;
    ddr_rd_ack_i = 1'b0; ddr_data_valid_i = 1'b0;
    full = 2'b00; wsel = 1'b0; rsel = 1'b0; rd_cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      ddr_rd_ack_i = 1'b0; ddr_data_valid_i = 1'b0;
      if (!rstn_i) begin
        phase = 0; full = 2'b00; wsel = 1'b0; rsel = 1'b0; rd_cnt = 0;
      end else begin
        if (s_ip_done) begin
          full = 2'b00; wsel = 1'b0; rsel = 1'b0;
        end else begin
          if (s_wr_done) begin full[wsel] = 1'b1; wsel = ~wsel; end
          if (s_rd_done) begin full[rsel] = 1'b0; rsel = ~rsel; end
        end
        if (s_rd_en) rd_cnt = s_rd_done ? 0 : rd_cnt + 1;
        if (phase == 0) begin
          if (ddr_rd_req_o) begin
            dly = (ack_delay_cfg >= 0) ? ack_delay_cfg : int'($urandom_range(0, 4));
            phase = 1;
          end else if (stray_en && $urandom_range(0, 3) == 0) begin
            ddr_data_valid_i = 1'b1;
          end
        end
        if (phase == 1) begin
          if (dly == 0) begin
            ddr_rd_ack_i = 1'b1;
            if (stray_en) ddr_data_valid_i = 1'b1;
            phase = 2; beats = 0;
          end else begin
            dly--;
          end
        end else if (phase == 2) begin
          if (!gap_en || $urandom_range(0, 1) == 1) begin
            ddr_data_valid_i = 1'b1;
            beats++;
            if (beats == WL + 1) phase = 0;
          end
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk_i) begin
    cyc++;
    if (!rstn_i) begin
      s_wr_done = 1'b0; s_rd_en = 1'b0; s_rd_done = 1'b0; s_ip_done = 1'b0; prev_req = 1'b0;
    end else begin
      s_wr_done = wr_buf_done_o; s_rd_en = rd_buf_en_o; s_rd_done = rd_buf_done_i; s_ip_done = ip_done_o;
      if (ddr_rd_req_o && !prev_req) begin
        req_cnt++;
        if (req_cnt == 2) req2_cyc = cyc;
        if (exp_addr_q.size() == 0) check("extra_req", 1, 0);
        else check("req_addr", ddr_rd_addr_o, exp_addr_q.pop_front());
        check("req_len", ddr_rd_len_o, WL + 1);
        req_addr_lat = ddr_rd_addr_o;
      end
      if (ddr_rd_req_o && ddr_rd_ack_i) check("req_addr_hold", ddr_rd_addr_o, req_addr_lat);
      prev_req = ddr_rd_req_o;
      if (wr_buf_en_o) begin
        check("wr_addr", wr_buf_addr_o, exp_waddr);
        exp_waddr--; wr_in_burst++;
      end
      if (wr_buf_done_o) begin
        check("wr_done_beats", wr_in_burst, WL + 1);
        wr_in_burst = 0; exp_waddr = WL;
      end
      if (ip_oneuron_start_o) begin
        check("start_buf_full", full[rsel], 1);
        check("start_dp_ready", dp_ready_i, 1);
        en_cnt = 0; start_cnt++;
      end
      if (rd_buf_en_o) en_cnt++;
      if (ip_oneuron_done_o) begin
        od_cnt++;
        if (od_cnt == 1) od1_cyc = cyc;
        check("rd_en_cycles", en_cnt, WL + 1);
        check("ip_done_with_last", ip_done_o, od_cnt == layer_n);
      end
      if (ip_done_o) ipdone_cnt++;
    end
  end

  task automatic check_reset_outputs();
    check("rst_req", ddr_rd_req_o, 0);
    check("rst_rd_addr", ddr_rd_addr_o, 0);
    check("rst_len", ddr_rd_len_o, 0);
    check("rst_wr_en", wr_buf_en_o, 0);
    check("rst_wr_addr", wr_buf_addr_o, WL);
    check("rst_wr_done", wr_buf_done_o, 0);
    check("rst_rd_en", rd_buf_en_o, 0);
    check("rst_start", ip_oneuron_start_o, 0);
    check("rst_od", ip_oneuron_done_o, 0);
    check("rst_ip_done", ip_done_o, 0);
    check("rst_busy", busy_o, 0);
  endtask

  task automatic start_layer(input int n, input logic [AW-1:0] base);
    init_model(n, base);
    @(posedge clk_i); #1;
    ip_neuron_num_i = NW'(n); ip_param_base_i = base; ip_start_i = 1'b1;
    @(posedge clk_i); #1;
    ip_start_i = 1'b0; ip_neuron_num_i = NW'($urandom); ip_param_base_i = AW'($urandom);
    @(negedge clk_i);
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_layer_done(input int n);
    int t;
    t = 0;
    while (ipdone_cnt == 0 && t < LIM) begin @(posedge clk_i); t++; end
    check("layer_timeout", t < LIM, 1);
    @(negedge clk_i);
    check("busy_cleared", busy_o, 0);
    check("req_count", req_cnt, n);
    check("start_count", start_cnt, n);
    check("oneuron_done_count", od_cnt, n);
    check("ip_done_count", ipdone_cnt, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : main
    int t, lat;
    rstn_i = 1'b0; ip_start_i = 1'b0; ip_neuron_num_i = '0; ip_param_base_i = '0; dp_ready_i = 1'b1;
    init_model(0, '0);
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (10) begin @(negedge clk_i); check_reset_outputs(); end

    // Single neuron, ack after 3 cycles, back-to-back beats
    ack_delay_cfg = 3;
    start_layer(1, 30'h100);
    wait_layer_done(1);

    // Three neurons from base 0 with stray beats outside the data phase
    ack_delay_cfg = -1; stray_en = 1'b1;
    start_layer(3, '0);
    wait_layer_done(3);
    stray_en = 1'b0;

    // Gappy beats, base near the top of the address space so it wraps
    gap_en = 1'b1;
    start_layer(2, 30'h3FFF_FF00);
    wait_layer_done(2);
    gap_en = 1'b0;

    // Datapath back-pressure with a full buffer, then drop ready during the read
    dp_ready_i = 1'b0;
    start_layer(1, AW'($urandom));
    t = 0;
    while (full[0] !== 1'b1 && t < LIM) begin @(posedge clk_i); t++; end
    check("fill_timeout", t < LIM, 1);
    repeat (100) @(posedge clk_i);
    check("no_start_while_not_ready", start_cnt, 0);
    #1 dp_ready_i = 1'b1;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!ip_oneuron_start_o && lat < 10);
    check("start_latency", lat, 2);
    @(posedge clk_i); #1 dp_ready_i = 1'b0;
    repeat (50) @(posedge clk_i);
    #1 dp_ready_i = 1'b1;
    wait_layer_done(1);

    // A start while busy is ignored
    start_layer(2, AW'($urandom));
    repeat (20) @(posedge clk_i);
    #1 ip_start_i = 1'b1; ip_neuron_num_i = NW'(7); ip_param_base_i = AW'($urandom);
    @(posedge clk_i); #1 ip_start_i = 1'b0;
    wait_layer_done(2);

    // Reset in the middle of a data burst
    start_layer(3, AW'($urandom));
    t = 0;
    while (wr_in_burst < 50 && t < LIM) begin @(posedge clk_i); t++; end
    check("reach_wdata_timeout", t < LIM, 1);
    #1 rstn_i = 1'b0;
    @(negedge clk_i); check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (3) begin @(negedge clk_i); check_reset_outputs(); end

    // Fresh layer after reset; fetch of neuron 1 relative to release of neuron 0
    start_layer(2, AW'($urandom));
    wait_layer_done(2);
`ifdef IP_SCHED_PREFETCH_EN
    check("req2_before_od1", req2_cyc < od1_cyc, 1);
`else
    check("req2_after_od1", req2_cyc > od1_cyc, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
